ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte from the FPGA to the keyboard (LED set 0xED, reset 0xFF, enable 0xF4, ...) over the same PS2_CLK/PS2_DATA pair the keyboard receiver listens on.
- Drives the lines open-drain via output-enable signals; the top level owns the inout tristate (oe=1 drives low, oe=0 releases).
- Raises `rx_inhibit` so the receiver ignores line activity during a transmission.
- Runs on the 100 MHz system clock.

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_host_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_FAIL
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_PKT_TO   = 2'b10;
  localparam logic [1:0] ERR_NO_ACK   = 2'b11;

  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_INHIBIT_US  = 120;
  localparam int DEF_START_TO_MS = 15;
  localparam int DEF_PKT_TO_MS   = 2;
  localparam int DEF_FILTER_LEN  = 8;
  localparam int MAX_RETRY       = 2;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // {stop, odd parity, data}; bit 0 goes on the wire first
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronizers, PS2_CLK glitch filter, falling-edge pulse.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_filt,
  output logic data_sync,
  output logic fall
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          clk_filt_q, clk_filt_d;
  logic          fall_q, fall_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_filt_d  = clk_filt_q;
    flt_cnt_d   = '0;
    // a new level must be seen FILTER_LEN times in a row before it is taken
    if (clk_sync_q[1] != clk_filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
      else                                  flt_cnt_d  = flt_cnt_q + 1'b1;
    end
    fall_d = clk_filt_q & ~clk_filt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      flt_cnt_q   <= '0;
      clk_filt_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      flt_cnt_q   <= flt_cnt_d;
      clk_filt_q  <= clk_filt_d;
      fall_q      <= fall_d;
    end
  end

  assign clk_filt  = clk_filt_q;
  assign data_sync = data_sync_q[1];
  assign fall      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain output enables.
// Optional macro PS2_TX_RETRY_EN: retry packet-timeout / no-ack failures up to twice.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * DEF_INHIBIT_US,
  parameter int START_TIMEOUT  = CLK_FREQ_HZ / 1_000 * DEF_START_TO_MS,
  parameter int PACKET_TIMEOUT = CLK_FREQ_HZ / 1_000 * DEF_PKT_TO_MS,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int MAX_TO = max_int(max_int(INHIBIT_CYCLES, START_TIMEOUT), PACKET_TIMEOUT);
  localparam int CW     = $clog2(MAX_TO + 1);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] pkt_q, pkt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          fail;
  logic [1:0]    fail_code;
  logic          pkt_to;

  logic clk_filt, data_sync, fall;

`ifdef PS2_TX_RETRY_EN
  logic [7:0] byte_q, byte_d;
  logic [1:0] retry_q, retry_d;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_filt    (clk_filt),
    .data_sync   (data_sync),
    .fall        (fall)
  );

  assign pkt_to = (pkt_q == CW'(PACKET_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == {CW{1'b1}}) ? timer_q : timer_q + 1'b1;
    pkt_d      = (pkt_q == {CW{1'b1}}) ? pkt_q : pkt_q + 1'b1;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
    byte_d     = byte_q;
    retry_d    = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d    = S_INHIBIT;
          timer_d    = '0;
          pkt_d      = '0;
          shreg_d    = ps2_frame(tx_data);
          bit_cnt_d  = '0;
          err_code_d = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
          byte_d     = tx_data;
          retry_d    = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (timer_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = S_REQ;
          timer_d = '0;
        end
      end
      S_REQ: begin
        // bit 0 is already at shreg_q[0]; the packet timer starts here
        if (fall) begin
          state_d = S_SHIFT;
          pkt_d   = CW'(1);
        end else if (timer_q == CW'(START_TIMEOUT - 1)) begin
          fail      = 1'b1;
          fail_code = ERR_START_TO;
        end
      end
      S_SHIFT: begin
        if (pkt_to) begin
          fail      = 1'b1;
          fail_code = ERR_PKT_TO;
        end else if (fall) begin
          shreg_d   = {1'b1, shreg_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd8) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (pkt_to) begin
          fail      = 1'b1;
          fail_code = ERR_PKT_TO;
        end else if (fall) begin
          if (!data_sync) state_d = S_WAIT_IDLE;
          else begin
            fail      = 1'b1;
            fail_code = ERR_NO_ACK;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (pkt_to) begin
          fail      = 1'b1;
          fail_code = ERR_PKT_TO;
        end else if (clk_filt && data_sync) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (fail_code != ERR_START_TO && retry_q != 2'(MAX_RETRY)) begin
        retry_d   = retry_q + 1'b1;
        state_d   = S_INHIBIT;
        timer_d   = '0;
        pkt_d     = '0;
        shreg_d   = ps2_frame(byte_q);
        bit_cnt_d = '0;
      end else begin
        state_d    = S_FAIL;
        err_code_d = fail_code;
      end
`else
      state_d    = S_FAIL;
      err_code_d = fail_code;
`endif
    end

    // outputs are registered decodes of the next state so the lines never glitch
    clk_oe_d = (state_d == S_INHIBIT);
    case (state_d)
      S_INHIBIT: data_oe_d = (timer_d == CW'(INHIBIT_CYCLES - 1));
      S_REQ:     data_oe_d = 1'b1;
      S_SHIFT:   data_oe_d = ~shreg_d[0];
      default:   data_oe_d = 1'b0;
    endcase
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pkt_q      <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pkt_q      <= pkt_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q  <= '0;
      retry_q <= '0;
    end else begin
      byte_q  <= byte_d;
      retry_q <= retry_d;
    end
  end
`endif

  assign tx_ready    = (state_q == S_IDLE);
  assign rx_inhibit  = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule
